ped_crossing_ctrl: RTL and testbench



---
 rtl/ped_crossing_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ped_crossing_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller downstream of the vehicle traffic-light FSM.
// WALK is granted only while vehicles see steady red-only. The controller aborts to
// STOP as soon as that condition is lost, and latches a sticky fault when it sees an
// illegal vehicle lamp combination.
module ped_crossing_ctrl #(
    parameter int unsigned RED_SETTLE = 1,
    parameter int unsigned TIME_WALK  = 8,
    parameter int unsigned TIME_FLASH = 8,
    parameter int unsigned FLASH_HALF = 2,
    parameter int unsigned CNT_W      = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       veh_red,
    input  logic       veh_yellow,
    input  logic       veh_green,
    input  logic       btn,
    output logic       walk,
    output logic       dont_walk,
    output logic       wait_lamp,
    output logic       fault,
    output logic [7:0] cross_count
);

    typedef enum logic [2:0] {StStop, StWalk, StFlash, StClear, StFault} state_e;

    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
    localparam logic [CNT_W-1:0] WalkLast  = CNT_W'(TIME_WALK - 1);
    localparam logic [CNT_W-1:0] FlashLast = CNT_W'(TIME_FLASH - 1);
    localparam logic [CNT_W-1:0] FlashHalf = CNT_W'(FLASH_HALF);
    localparam logic [3:0]       RedSettle = 4'(RED_SETTLE);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       red_cnt_q, red_cnt_d;
    logic             req_q, req_d;
    logic [7:0]       cross_q, cross_d;
    logic             btn_q;
    logic             walk_q, dont_walk_q, wait_q, fault_q;
    logic             walk_d, dont_walk_d;

    logic             red_only, legal, illegal, rise, enter_walk;
    logic [CNT_W-1:0] flash_idx;

    // Lamp decode: legal combinations are R, R+Y, G and Y; everything else is a fault.
    always_comb begin
        red_only = veh_red & ~veh_yellow & ~veh_green;
        legal    = red_only
                 | ( veh_red &  veh_yellow & ~veh_green)
                 | (~veh_red & ~veh_yellow &  veh_green)
                 | (~veh_red &  veh_yellow & ~veh_green);
        illegal  = ~legal;
        rise     = btn & ~btn_q;
    end

    // Red settle counter saturates at 15 and clears on any non-red-only cycle.
    always_comb begin
        red_cnt_d = 4'd0;
        if (red_only) begin
            red_cnt_d = (red_cnt_q == 4'd15) ? 4'd15 : red_cnt_q + 4'd1;
        end
    end

    // Next state, phase counter, request latch and crossing counter.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cross_d    = cross_q;
        enter_walk = 1'b0;
        if (illegal) begin
            state_d = StFault;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StStop: begin
                    if (req_q && red_only && (red_cnt_q >= RedSettle)) begin
                        state_d    = StWalk;
                        cnt_d      = '0;
                        enter_walk = 1'b1;
                        cross_d    = cross_q + 8'd1;
                    end
                end
                StWalk: begin
                    if (!red_only) begin
                        state_d = StStop;
                        cnt_d   = '0;
                    end else if (cnt_q == WalkLast) begin
                        state_d = StFlash;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StFlash: begin
                    if (!red_only) begin
                        state_d = StStop;
                        cnt_d   = '0;
                    end else if (cnt_q == FlashLast) begin
                        state_d = StClear;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StClear: begin
                    // Requests are only served once a fresh red phase has started.
                    if (!red_only) begin
                        state_d = StStop;
                    end
                end
                StFault: begin
                    state_d = StFault;
                end
                default: begin
                    state_d = StFault;
                end
            endcase
        end

        req_d = req_q;
        if (state_d == StFault || enter_walk) begin
            req_d = 1'b0;
        end else if (rise && (state_q == StStop || state_q == StFlash
                              || state_q == StClear)) begin
            req_d = 1'b1;
        end
    end

    // Outputs are decoded from the next state so the registered lamps track state_q.
    always_comb begin
        flash_idx   = cnt_d / FlashHalf;
        walk_d      = (state_d == StWalk);
        dont_walk_d = (state_d == StFlash) ? ~flash_idx[0] : (state_d != StWalk);
    end

    // State, counters and registered outputs; synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StStop;
            cnt_q       <= '0;
            red_cnt_q   <= 4'd0;
            req_q       <= 1'b0;
            cross_q     <= 8'd0;
            btn_q       <= 1'b1;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
            wait_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            red_cnt_q   <= red_cnt_d;
            req_q       <= req_d;
            cross_q     <= cross_d;
            btn_q       <= btn;
            walk_q      <= walk_d;
            dont_walk_q <= dont_walk_d;
            wait_q      <= req_d;
            fault_q     <= (state_d == StFault);
        end
    end

    assign walk        = walk_q;
    assign dont_walk   = dont_walk_q;
    assign wait_lamp   = wait_q;
    assign fault       = fault_q;
    assign cross_count = cross_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed self-checking bench for ped_crossing_ctrl.
module tb_ped_crossing_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       veh_red, veh_yellow, veh_green;
    logic       btn;
    logic       walk, dont_walk, wait_lamp, fault;
    logic [7:0] cross_count;

    int checks = 0;
    int errors = 0;

    ped_crossing_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .veh_red    (veh_red),
        .veh_yellow (veh_yellow),
        .veh_green  (veh_green),
        .btn        (btn),
        .walk       (walk),
        .dont_walk  (dont_walk),
        .wait_lamp  (wait_lamp),
        .fault      (fault),
        .cross_count(cross_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic veh(input logic r, input logic y, input logic g);
        veh_red    = r;
        veh_yellow = y;
        veh_green  = g;
    endtask

    // Compares {walk, dont_walk, wait_lamp, fault} against the expected nibble.
    task automatic chk_out(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {walk, dont_walk, wait_lamp, fault};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed w/dw/wait/flt=%b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_cc(input string tag, input logic [7:0] exp);
        checks++;
        assert (cross_count === exp) else begin
            errors++;
            $error("FAIL %s observed cross_count=%0d expected %0d", tag, cross_count, exp);
        end
    endtask

    // From STOP with btn low: press under red, enter WALK, then abort via R+Y.
    task automatic quick_walk();
        veh(1, 0, 0);
        btn = 1'b1;
        step();
        btn = 1'b0;
        step();
        veh(1, 1, 0);
        step();
    endtask

    initial begin
        logic [7:0] pat;
        pat = 8'b1100_1100;

        // Reset and idle under steady red.
        rst = 1'b1;
        btn = 1'b0;
        veh(1, 0, 0);
        step();
        step();
        chk_out("reset_outputs", 4'b0100);
        chk_cc("reset_count", 8'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk_out("idle_red", 4'b0100);
        end
        chk_cc("idle_count", 8'd0);

        // Press on green, then yellow, then red.
        veh(0, 0, 1);
        btn = 1'b1;
        step();
        chk_out("req_on_green", 4'b0110);
        btn = 1'b0;
        veh(0, 1, 0);
        step();
        chk_out("req_on_yellow", 4'b0110);
        veh(1, 0, 0);
        step();
        chk_out("red_settling", 4'b0110);
        step();
        chk_cc("first_walk_count", 8'd1);
        for (int i = 0; i < 8; i++) begin
            chk_out("walk_phase", 4'b1000);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            chk_out("flash_phase", {1'b0, pat[7-i], 2'b00});
            step();
        end
        chk_out("clear_phase", 4'b0100);

        // Red held long: no second WALK without a new press.
        for (int i = 0; i < 30; i++) begin
            step();
            chk_out("red_hold_no_walk", 4'b0100);
        end
        chk_cc("single_walk_count", 8'd1);
        veh(0, 0, 1);
        step();
        btn = 1'b1;
        step();
        btn = 1'b0;
        chk_out("second_req", 4'b0110);
        veh(0, 1, 0);
        step();
        veh(1, 0, 0);
        step();
        step();
        chk_out("second_walk", 4'b1000);
        chk_cc("second_walk_count", 8'd2);

        // Abort at WALK cycle 3.
        step();
        step();
        chk_out("walk_before_abort", 4'b1000);
        veh(1, 1, 0);
        step();
        chk_out("abort_stop", 4'b0100);
        step();
        chk_out("abort_hold", 4'b0100);

        // Button pressed during WALK is ignored.
        veh(1, 0, 0);
        btn = 1'b1;
        step();
        btn = 1'b0;
        step();
        chk_out("third_walk", 4'b1000);
        chk_cc("third_walk_count", 8'd3);
        btn = 1'b1;
        step();
        chk_out("btn_in_walk", 4'b1000);
        btn = 1'b0;
        veh(1, 1, 0);
        step();
        chk_out("btn_in_walk_dropped", 4'b0100);

        // Drive cross_count to 255, then wrap.
        for (int i = 0; i < 252; i++) begin
            quick_walk();
        end
        chk_cc("count_255", 8'd255);
        quick_walk();
        chk_cc("count_wrap", 8'd0);
        chk_out("after_wrap", 4'b0100);

        // Fault: G+R for one cycle is sticky; presses are ignored.
        veh(1, 0, 1);
        step();
        chk_out("fault_set", 4'b0101);
        veh(1, 0, 0);
        btn = 1'b1;
        step();
        btn = 1'b0;
        step();
        step();
        step();
        chk_out("fault_sticky", 4'b0101);
        veh(0, 0, 0);
        step();
        chk_out("fault_none_lit", 4'b0101);

        // Reset clears fault; button held across release is not a request.
        veh(1, 0, 0);
        btn = 1'b1;
        rst = 1'b1;
        step();
        chk_out("fault_cleared", 4'b0100);
        chk_cc("reset_count_again", 8'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("btn_held_over_reset", 4'b0100);
        end
        btn = 1'b0;
        step();
        step();
        chk_out("btn_release_no_req", 4'b0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
